// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - single-outstanding command issuer for the 4-bit ALU
//
// Accepts one command (a, b, c, sel) over a valid/ready handshake, drives the
// ALU operand/sel inputs, waits out the ALU register latency, captures the
// result and returns it on a valid/ready response channel.
//
// Optional feature macro: DIV0_GUARD_EN
//   When defined, div/mod commands with cmd_b == 0 bypass the ALU and return
//   rsp_data = all ones with rsp_err = 1. When undefined, rsp_err stays 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_a/cmd_b/cmd_c/cmd_sel  command operands and opcode
//   alu_a/alu_b/alu_c/alu_sel  registered drive to the ALU
//   alu_result                 result from the ALU
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/rsp_err           captured result and divide-by-zero flag
//   done_cnt                   completed-response counter (wraps)
module alu_cmd_issuer #(
  parameter int DATA_W  = 4,
  parameter int RES_W   = 5,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_c,
  input  logic [2:0]        cmd_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_c,
  output logic [2:0]        alu_sel,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [7:0]        done_cnt
);

  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             div0;

  // Only div (011) and mod (100) with a zero divisor are short-circuited.
`ifdef DIV0_GUARD_EN
  assign div0 = ((cmd_sel == 3'b011) || (cmd_sel == 3'b100)) && (cmd_b == '0);
`else
  assign div0 = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_c     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rsp_err <= div0;
            if (div0) begin
              // Guarded command: ALU inputs left untouched, answer directly.
              rsp_data  <= {RES_W{1'b1}};
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_a    <= cmd_a;
              alu_b    <= cmd_b;
              alu_c    <= cmd_c;
              alu_sel  <= cmd_sel;
              wait_cnt <= CNT_W'(ALU_LAT);
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          // Counter reaches zero one edge after the ALU output has settled,
          // so capture lands ALU_LAT+1 edges after the accept edge.
          if (wait_cnt == '0) begin
            rsp_data  <= alu_result;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer with an ALU model
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_c;
  logic [2:0] cmd_sel;
  logic [3:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_sel;
  logic [4:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic       rsp_err;
  logic [7:0] done_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];   // {err, data}
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DATA_W(4), .RES_W(5), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .done_cnt(done_cnt)
  );

  function automatic logic [4:0] alu_ref(logic [3:0] a, logic [3:0] b,
                                         logic [3:0] c, logic [2:0] s);
    logic [3:0] m;
    case (s)
      3'd0: begin
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return {1'b0, m};
      end
      3'd1: return {1'b0, a} + {1'b0, b};
      3'd2: return {1'b0, a} - {1'b0, b};
      3'd3: return (b == 4'd0) ? 5'd0 : {1'b0, a / b};
      3'd4: return (b == 4'd0) ? 5'd0 : {1'b0, a % b};
      3'd5: return {a, 1'b0};
      3'd6: return {2'b0, a[3:1]};
      default: return {4'd0, a > b};
    endcase
  endfunction

  // One-stage registered ALU model.
  always_ff @(posedge clk) alu_result <= alu_ref(alu_a, alu_b, alu_c, alu_sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command and consume its response after hold cycles of back-pressure.
  task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [2:0] s, input logic [4:0] exp_data, input logic exp_err,
                        input int exp_lat, input int hold);
    int lat;
    logic [5:0] e;
    logic [3:0] a_before;
    a_before = alu_a;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_sel = s; cmd_valid = 1'b1;
    exp_q.push_back({exp_err, exp_data});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    while (!rsp_valid && lat < 20) lat++;
    lat = (lat == 0) ? 1 : lat;
    check("latency", lat, exp_lat);
    if (exp_err) check("alu_a_untouched", alu_a, a_before);
    else         check("alu_a_driven", alu_a, a);
    e = exp_q.pop_front();
    check("rsp_data", rsp_data, e[4:0]);
    check("rsp_err", rsp_err, e[5]);
    // Back-pressure: data held, no accept of a competing command.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = ~a; cmd_sel = s + 3'd1;
      check("hold_ready", cmd_ready, 0);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, e[4:0]);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("rsp_valid_drop", rsp_valid, 0);
    check("done_cnt", done_cnt, exp_cnt);
    if (!exp_err) check("alu_a_held", alu_a, a);
  endtask

  initial begin
    logic [3:0] ra, rb, rc;
    logic [2:0] rs;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_sel = '0;
    exp_cnt = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge clk); rst_n = 1'b1;

    do_txn(4'd9, 4'd8, 4'd0, 3'b001, 5'h11, 1'b0, 2, 0);
    do_txn(4'd3, 4'd12, 4'd7, 3'b000, 5'd12, 1'b0, 2, 0);
    do_txn(4'd2, 4'd5, 4'd0, 3'b010, 5'h1D, 1'b0, 2, 0);
    do_txn(4'd13, 4'd4, 4'd0, 3'b011, 5'd3, 1'b0, 2, 0);
    do_txn(4'd13, 4'd4, 4'd0, 3'b100, 5'd1, 1'b0, 2, 5);
    do_txn(4'd5, 4'd3, 4'd0, 3'b111, 5'd1, 1'b0, 2, 0);
`ifdef DIV0_GUARD_EN
    do_txn(4'd7, 4'd0, 4'd0, 3'b011, 5'h1F, 1'b1, 1, 1);
    do_txn(4'd6, 4'd0, 4'd0, 3'b100, 5'h1F, 1'b1, 1, 0);
    do_txn(4'd6, 4'd2, 4'd0, 3'b100, 5'd0, 1'b0, 2, 0);
`else
    do_txn(4'd7, 4'd0, 4'd0, 3'b011, alu_ref(4'd7, 4'd0, 4'd0, 3'b011), 1'b0, 2, 1);
`endif

    // Reset during WAIT: command aborted, counter cleared, no response.
    @(negedge clk);
    cmd_a = 4'd1; cmd_b = 4'd1; cmd_sel = 3'b001; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("wait_not_ready", cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", cmd_ready, 1);
    check("midrst_valid", rsp_valid, 0);
    check("midrst_cnt", done_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    exp_cnt = 8'd0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 0);
    end

    // 256 random transactions: done_cnt must wrap back to 0.
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(1, 15));
      rc = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      do_txn(ra, rb, rc, rs, alu_ref(ra, rb, rc, rs), 1'b0, 2, i % 3);
    end
    check("wrap_done_cnt", done_cnt, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
